// File: rtl/aes_plat_pkg.sv
// Shared constants, state encoding and counter helper for the AES receive checker.
// Pure definitions; no logic or latency of its own.
package aes_plat_pkg;

  localparam int BLK_BYTES = 16;
  localparam int BLK_W     = BLK_BYTES * 8;
  localparam int IDX_W     = $clog2(BLK_BYTES);
  localparam int CNT_W     = 32;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMPARE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  // Saturating increment: verdict counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-flop synchroniser on an async strobe with rising-edge detect; data bus delayed in step.
// evt is valid 2 clk edges after the strobe is sampled high; a strobe already high at reset release is ignored.
module sync_edge #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          strb_in,
  input  logic [DW-1:0] dat_in,
  output logic          evt,
  output logic [DW-1:0] dat_out
);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          prev_q, prev_d;
  logic [1:0]    arm_q, arm_d;
  logic [DW-1:0] d1_q, d1_d;
  logic [DW-1:0] d2_q, d2_d;

  always_comb begin
    s1_d  = strb_in;
    s2_d  = s1_q;
    d1_d  = dat_in;
    d2_d  = d1_q;
    arm_d = {arm_q[0], 1'b1};
    // Until s2 carries a real post-reset sample, pretend the strobe was high so no edge is seen.
    prev_d = arm_q[1] ? s2_q : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b1;
      arm_q  <= 2'b00;
      d1_q   <= '0;
      d2_q   <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
    end
  end

  assign evt     = arm_q[1] & s2_q & ~prev_q;
  assign dat_out = d2_q;

endmodule

// File: rtl/aes_rx_checker.sv
// Collects 16 strobed ciphertext bytes from the chip and compares them against a loaded expected block.
// blk_done pulses 2 cycles after the 16th byte event; exp_ready is the only backpressure (high in IDLE with work=1).
module aes_rx_checker
  import aes_plat_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               work,
  input  logic [8:0]         aes_rx,
  input  logic [BLK_W-1:0]   exp_data,
  input  logic               exp_valid,
  output logic               exp_ready,
  output logic               blk_done,
  output logic               blk_match,
  output logic [CNT_W-1:0]   total,
  output logic [CNT_W-1:0]   correct,
  output logic               err_stray
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  if (TIMEOUT_CYC < 2 || CLK_FREQ < 1) begin : g_bad_cfg
    $error("aes_rx_checker: TIMEOUT_CYC must be at least 2 and CLK_FREQ positive");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [BLK_W-1:0] exp_q, exp_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             blk_match_q, blk_match_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] correct_q, correct_d;
  logic             err_stray_q, err_stray_d;

  logic             byte_evt;
  logic [7:0]       byte_dat;

  sync_edge #(
    .DW (8)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .strb_in (aes_rx[8]),
    .dat_in  (aes_rx[7:0]),
    .evt     (byte_evt),
    .dat_out (byte_dat)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    exp_d       = exp_q;
    blk_d       = blk_q;
    blk_match_d = blk_match_q;
    total_d     = total_q;
    correct_d   = correct_q;
    err_stray_d = err_stray_q;

    // Only COLLECT consumes bytes; this includes the cycle of the IDLE->COLLECT hop.
    if (byte_evt && state_q != ST_COLLECT) err_stray_d = 1'b1;

    if (!work) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (exp_valid) begin
            exp_d   = exp_data;
            idx_d   = '0;
            tmr_d   = '0;
            state_d = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (byte_evt) begin
            // Shifting in MSB-first leaves byte 0 in the top lane after 16 bytes.
            blk_d = {blk_q[BLK_W-9:0], byte_dat};
            idx_d = idx_q + IDX_W'(1);
            tmr_d = '0;
            if (idx_q == IDX_LAST) state_d = ST_COMPARE;
          end else if (idx_q != '0) begin
            if (tmr_q == TMO_LAST) begin
              blk_match_d = 1'b0;
              total_d     = sat_inc(total_q);
              state_d     = ST_REPORT;
            end else begin
              tmr_d = tmr_q + TW'(1);
            end
          end
        end
        ST_COMPARE: begin
          // Verdict registers load on entry to REPORT so they are valid alongside blk_done.
          blk_match_d = (blk_q == exp_q);
          total_d     = sat_inc(total_q);
          if (blk_q == exp_q) correct_d = sat_inc(correct_q);
          state_d     = ST_REPORT;
        end
        ST_REPORT: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tmr_q       <= '0;
      exp_q       <= '0;
      blk_q       <= '0;
      blk_match_q <= 1'b0;
      total_q     <= '0;
      correct_q   <= '0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      exp_q       <= exp_d;
      blk_q       <= blk_d;
      blk_match_q <= blk_match_d;
      total_q     <= total_d;
      correct_q   <= correct_d;
      err_stray_q <= err_stray_d;
    end
  end

  assign exp_ready = rst_n & work & (state_q == ST_IDLE);
  assign blk_done  = rst_n & (state_q == ST_REPORT);
  assign blk_match = blk_match_q;
  assign total     = total_q;
  assign correct   = correct_q;
  assign err_stray = err_stray_q;

endmodule

// File: tb/tb_aes_rx_checker.sv
// Directed and randomized bench for aes_rx_checker against a byte-level verdict/counter model.
module tb_aes_rx_checker;

  localparam int TMO      = 200;
  localparam int HALF_BIT = 10;  // strobe high/low cycles: 50 kHz strobe on a 1 MHz clock

  logic         clk = 1'b0;
  logic         rst_n;
  logic         work;
  logic [8:0]   aes_rx;
  logic [127:0] exp_data;
  logic         exp_valid;
  logic         exp_ready;
  logic         blk_done;
  logic         blk_match;
  logic [31:0]  total;
  logic [31:0]  correct;
  logic         err_stray;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic [31:0] m_total, m_correct;
  logic        m_stray, m_match;

  aes_rx_checker #(
    .CLK_FREQ    (1_000_000),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .work      (work),
    .aes_rx    (aes_rx),
    .exp_data  (exp_data),
    .exp_valid (exp_valid),
    .exp_ready (exp_ready),
    .blk_done  (blk_done),
    .blk_match (blk_match),
    .total     (total),
    .correct   (correct),
    .err_stray (err_stray)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (blk_done) done_cnt++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_total"}, total, m_total);
    check({tag, "_correct"}, correct, m_correct);
    check({tag, "_stray"}, err_stray, m_stray);
    check({tag, "_ratio"}, correct <= total, 1'b1);
  endtask

  task automatic do_reset(input logic strb);
    @(negedge clk);
    rst_n     = 1'b0;
    exp_valid = 1'b0;
    aes_rx    = {strb, 8'h00};
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    m_total   = '0;
    m_correct = '0;
    m_stray   = 1'b0;
    m_match   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_exp(input logic [127:0] e);
    @(negedge clk);
    check("exp_ready_idle", exp_ready, 1'b1);
    exp_data  = e;
    exp_valid = 1'b1;
    @(negedge clk);
    exp_valid = 1'b0;
    exp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    check("exp_ready_busy", exp_ready, 1'b0);
  endtask

  // blk_done is expected only at the negedge after the 4th posedge following the strobe rise.
  task automatic send_byte(input logic [7:0] b, input bit last, output logic match_seen);
    logic [HALF_BIT-1:0] seen;
    seen       = '0;
    match_seen = 1'b0;
    @(negedge clk);
    #($urandom_range(1, 3));
    aes_rx = {1'b1, b};
    for (int k = 1; k <= HALF_BIT; k++) begin
      @(negedge clk);
      seen[k-1] = blk_done;
      if (k == 4) match_seen = blk_match;
    end
    check(last ? "done_timing_last" : "done_timing_mid", seen,
          last ? 10'b00_0000_1000 : 10'b0);
    #($urandom_range(1, 3));
    aes_rx[8] = 1'b0;
    repeat (HALF_BIT) @(negedge clk);
  endtask

  task automatic run_block(input string tag, input logic [127:0] e, input logic [127:0] sent);
    logic ms;
    logic any_diff;
    int   d0;
    d0 = done_cnt;
    load_exp(e);
    for (int i = 0; i < 16; i++) send_byte(sent[127-8*i -: 8], i == 15, ms);
    any_diff = 1'b0;
    for (int i = 0; i < 16; i++) if (sent[127-8*i -: 8] != e[127-8*i -: 8]) any_diff = 1'b1;
    m_total = m_sat(m_total);
    m_match = !any_diff;
    if (m_match) m_correct = m_sat(m_correct);
    check({tag, "_match"}, ms, m_match);
    check({tag, "_ndone"}, done_cnt - d0, 1);
    check({tag, "_match_held"}, blk_match, m_match);
    check_counters(tag);
  endtask

  initial begin
    logic [127:0] s1;
    logic [127:0] sent;
    logic         ms;
    int           d0;
    int           first;

    s1        = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    rst_n     = 1'b0;
    work      = 1'b1;
    aes_rx    = 9'h1FF;
    exp_valid = 1'b0;
    exp_data  = '0;

    // Reset values, with work=1 and the strobe held high across release.
    repeat (3) @(negedge clk);
    check("rst_exp_ready", exp_ready, 1'b0);
    check("rst_blk_done", blk_done, 1'b0);
    check("rst_blk_match", blk_match, 1'b0);
    check("rst_total", total, 32'd0);
    check("rst_correct", correct, 32'd0);
    check("rst_stray", err_stray, 1'b0);
    rst_n = 1'b1;
    m_total = '0; m_correct = '0; m_stray = 1'b0; m_match = 1'b0;
    repeat (8) @(negedge clk);
    check("rel_high_strobe_no_event", err_stray, 1'b0);
    check("rel_exp_ready", exp_ready, 1'b1);
    aes_rx[8] = 1'b0;
    repeat (4) @(negedge clk);

    // Scenario 1: matching block.
    run_block("s1", s1, s1);

    // Scenario 2: byte 7 corrupted.
    do_reset(1'b0);
    sent = s1;
    sent[127-8*7 -: 8] = 8'h00;
    run_block("s2", s1, sent);

    // Scenario 3: 5 bytes then silence -> timeout verdict.
    do_reset(1'b0);
    d0 = done_cnt;
    load_exp(s1);
    for (int i = 0; i < 4; i++) send_byte(s1[127-8*i -: 8], 1'b0, ms);
    first = 0;
    @(negedge clk);
    #2;
    aes_rx = {1'b1, s1[127-8*4 -: 8]};
    for (int k = 1; k <= TMO + 20; k++) begin
      @(negedge clk);
      if (k == HALF_BIT) aes_rx[8] = 1'b0;
      if (blk_done && first == 0) begin
        first = k;
        ms    = blk_match;
      end
    end
    m_total = m_sat(m_total);
    check("s3_tmo_latency", first, TMO + 3);
    check("s3_match", ms, 1'b0);
    check("s3_ndone", done_cnt - d0, 1);
    check("s3_back_idle", exp_ready, 1'b1);
    check_counters("s3");

    // Scenario 4: stray byte with nothing loaded, then a normal block.
    do_reset(1'b0);
    send_byte(8'hA5, 1'b0, ms);
    m_stray = 1'b1;
    check_counters("s4_stray");
    run_block("s4", s1, s1);

    // Scenario 5: work dropped after 10 bytes.
    do_reset(1'b0);
    load_exp(s1);
    for (int i = 0; i < 10; i++) send_byte(s1[127-8*i -: 8], 1'b0, ms);
    d0 = done_cnt;
    @(negedge clk);
    work = 1'b0;
    repeat (20) @(negedge clk);
    check("s5_no_done", done_cnt - d0, 0);
    check("s5_ready_off", exp_ready, 1'b0);
    check_counters("s5_hold");
    work = 1'b1;
    run_block("s5", s1, s1);

    // Reset mid-block discards collected bytes without a verdict.
    do_reset(1'b0);
    d0 = done_cnt;
    load_exp(s1);
    for (int i = 0; i < 8; i++) send_byte(s1[127-8*i -: 8], 1'b0, ms);
    do_reset(1'b0);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check_counters("mid_rst");
    run_block("after_rst", s1, s1);

    // Scenario 6: counter saturation.
    do_reset(1'b0);
    @(negedge clk);
    force dut.total_q   = 32'hFFFF_FFFE;
    force dut.correct_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.total_q;
    release dut.correct_q;
    m_total   = 32'hFFFF_FFFE;
    m_correct = 32'hFFFF_FFFE;
    for (int b = 0; b < 3; b++) run_block("s6", s1, s1);
    check("s6_total_sat", total, 32'hFFFF_FFFF);
    check("s6_correct_sat", correct, 32'hFFFF_FFFF);

    // Random blocks, roughly half with a corrupted byte.
    do_reset(1'b0);
    for (int b = 0; b < 6; b++) begin
      logic [127:0] e;
      int           pos;
      logic [7:0]   flip;
      e    = {$urandom(), $urandom(), $urandom(), $urandom()};
      sent = e;
      if ($urandom_range(0, 1) == 1) begin
        pos  = $urandom_range(0, 15);
        flip = 8'($urandom_range(1, 255));
        sent[127-8*pos -: 8] = sent[127-8*pos -: 8] ^ flip;
      end
      run_block("rnd", e, sent);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_rx_checker.md
AES_RX_CHECKER -- requirements
Module: aes_rx_checker

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz (informational only).
REQ-002 Parameter TIMEOUT_CYC, default 100_000, number of idle clk cycles allowed between bytes inside one block.
REQ-003 clk  input  1  system clock; the block has one clock, and all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 work  input  1  check enable from the platform controller.
REQ-006 aes_rx  input  9  chip output bus: [7:0] is the byte, [8] is the sho strobe; it is asynchronous to clk.
REQ-007 exp_data  input  128  expected ciphertext block, byte 0 in [127:120].
REQ-008 exp_valid  input  1  exp_data is valid.
REQ-009 exp_ready  output  1  checker accepts exp_data this cycle.
REQ-010 blk_done  output  1  one-cycle pulse when a block verdict is issued.
REQ-011 blk_match  output  1  verdict of the last block, valid while blk_done=1 and held until the next verdict.
REQ-012 total  output  32  count of verdicts issued.
REQ-013 correct  output  32  count of matching verdicts.
REQ-014 err_stray  output  1  sticky flag: a byte arrived while no expected block was loaded.

Function
REQ-015 Synchronisation: aes_rx[8] shall pass through a 2-flop synchroniser; a byte event is a rising edge of the synchronised strobe.
REQ-016 Data capture: aes_rx[7:0] shall be captured from a register that is 2-flop delayed in step with the strobe, in the same cycle as the byte event.
REQ-017 The state machine has four states: IDLE, COLLECT, COMPARE, REPORT.
REQ-018 IDLE: exp_ready=1 while work=1; when exp_valid&&exp_ready, latch exp_data, clear the byte index to 0, and go to COLLECT.
REQ-019 COLLECT: on each byte event, store the byte at index idx (MSB first) and increment idx; on the 16th byte (idx=15), go to COMPARE.
REQ-020 COMPARE: compare the 128-bit collected block with the latched expected block in one cycle, then go to REPORT.
REQ-021 REPORT: pulse blk_done for 1 cycle and update blk_match; total+=1, and correct+=1 if matched; return to IDLE.
REQ-022 Latency: blk_done shall assert exactly 2 cycles after the cycle in which the 16th byte event is detected.
REQ-023 Timeout: in COLLECT with idx>0, if TIMEOUT_CYC cycles pass with no byte event, issue a verdict with blk_match=0 (total+=1) via REPORT; the timer restarts on every byte event.
REQ-024 Stray byte: a byte event in IDLE, COMPARE or REPORT shall be dropped and shall set err_stray; err_stray clears only on reset.
REQ-025 Simultaneous events: exp_valid is ignored outside IDLE (exp_ready=0); a byte event in the same cycle as the IDLE->COLLECT transition is stray.
REQ-026 work=0: from any state, go to IDLE next cycle, discard the partial block without a verdict, and hold total, correct and err_stray.
REQ-027 Counters shall saturate at 32'hFFFF_FFFF and never wrap.
REQ-028 The ratio correct <= total shall hold at all times.

Reset
REQ-029 rst_n=0 at a clk edge shall give: state IDLE, idx 0, timer 0, synchroniser flops 0.
REQ-030 rst_n=0 shall also give: exp_ready=0 during reset, blk_done=0, blk_match=0, total=0, correct=0, err_stray=0.
REQ-031 Reset mid-block shall discard all collected bytes and issue no verdict.
REQ-032 The first byte event after reset requires a strobe low->high seen after reset; a strobe already high at reset release is not an event.

Structure
REQ-033 A shared package aes_plat_pkg shall hold BLK_BYTES=16, the state encoding, and the counter width 32.
REQ-034 One sub-module, sync_edge (2-flop synchroniser plus rising-edge detect, with data delay matched), shall be instantiated once.
REQ-035 No other hierarchy is used, and the datapath shall contain no combinational path from aes_rx to any output.

Verification
REQ-036 Scenario 1: load exp=0x69C4E0D86A7B0430D8CDB78070B4C55A, then drive the 16 matching bytes 0x69..0x5A with the strobe at 50 kHz -> one blk_done, blk_match=1, total=1, correct=1.
REQ-037 Scenario 2: same stimulus with byte 7 corrupted to 0x00 -> blk_match=0, total=1, correct=0.
REQ-038 Scenario 3: send 5 bytes, then stay silent for TIMEOUT_CYC+1 cycles -> blk_done with blk_match=0, total=1, and the state returns to IDLE.
REQ-039 Scenario 4: send 1 byte with no exp_valid -> err_stray=1, total=0; then run a normal block -> blk_match=1 and err_stray stays 1.
REQ-040 Scenario 5: drop work to 0 after 10 bytes -> no blk_done, counters held; raise work, run a full block -> total=1.
REQ-041 Scenario 6: preload total=32'hFFFF_FFFE through a force/backdoor and run 3 matching blocks -> total=correct=32'hFFFF_FFFF.
